// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the 5-stage MIPS pipeline: owns the PC, drives the
// instruction memory address, loads IF/ID and arbitrates redirects against stalls.
`timescale 1ns/1ps
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             br_take_i,
    input  logic [31:0]      br_target_i,
    input  logic             j_take_i,
    input  logic [31:0]      j_target_i,
    input  logic             jr_take_i,
    input  logic [31:0]      jr_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             flush_idex_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [31:0] ALIGN_MASK = ~32'd3;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      pc4_q;
    logic             valid_q;
    logic [CNT_W-1:0] fetch_q;
    logic [CNT_W-1:0] bubble_q;
    logic [31:0]      pc_inc;
    logic [CNT_W-1:0] fetch_d;
    logic [CNT_W-1:0] bubble_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return (&v) ? v : v + one;
    endfunction

    always_comb begin
        pc_inc   = pc_q + 32'd4;
        fetch_d  = sat_inc(fetch_q);
        bubble_d = sat_inc(bubble_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= PC_RESET;
            instr_q  <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
            fetch_q  <= '0;
            bubble_q <= '0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // Priority: halt, then the older EX branch, then stall, then ID jumps.
                    if (halt_i) begin
                        state_q <= HALT;
                        valid_q <= 1'b0;
                    end else if (br_take_i) begin
                        pc_q     <= br_target_i & ALIGN_MASK;
                        valid_q  <= 1'b0;
                        bubble_q <= bubble_d;
                    end else if (stall_i) begin
                        bubble_q <= bubble_d;
                    end else if (jr_take_i) begin
                        pc_q     <= jr_target_i & ALIGN_MASK;
                        valid_q  <= 1'b0;
                        bubble_q <= bubble_d;
                    end else if (j_take_i) begin
                        pc_q     <= j_target_i & ALIGN_MASK;
                        valid_q  <= 1'b0;
                        bubble_q <= bubble_d;
                    end else begin
                        pc_q    <= pc_inc;
                        instr_q <= imem_instr_i;
                        pc4_q   <= pc_inc;
                        valid_q <= 1'b1;
                        fetch_q <= fetch_d;
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= BOOT;
            endcase
        end
    end

    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = instr_q;
    assign ifid_pc4_o   = pc4_q;
    assign ifid_valid_o = valid_q;
    assign flush_idex_o = (state_q == RUN) & br_take_i & ~halt_i;
    assign state_o      = state_q;
    assign fetch_cnt_o  = fetch_q;
    assign bubble_cnt_o = bubble_q;

endmodule
